serial_addsub: RTL and testbench

- Bit-serial adder/subtractor built around a single full-adder cell and a registered carry.
- Accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first.
- Reports the sum, carry-out and signed overflow with a one-cycle done pulse.
- Serves as the area-minimal arithmetic consumer for operand streams in the combinational-circuit library.

---
 rtl/serial_addsub.sv | 145 ++++++++++++++
 tb/tb_serial_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry, LSB first.
// Latency: o_done pulses WIDTH edges after the accepting start edge; one op per WIDTH+2 cycles.
// Backpressure: none; i_start is only honoured in IDLE, ignored while busy or during done.
//
// Ports:
//   i_clk, i_rst         rising-edge clock, synchronous active-high reset
//   i_start              start strobe (sampled in IDLE only)
//   i_A, i_B, i_Cin      operands and add-mode carry-in, captured on accepted start
//   i_Sub                0 = A+B+Cin, 1 = A-B (Cin ignored), captured on accepted start
//   o_busy               high for the WIDTH cycles of a computation
//   o_done               one-cycle pulse when results are valid
//   o_Sum, o_Cout, o_Ovf result, final carry (NOT borrow in sub mode), signed overflow;
//                        held until the next operation completes
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_Sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic             o_Ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    // Partial result: WIDTH-1 bits suffice because the final bit is merged
    // combinationally on the last edge straight into the output register.
    logic [WIDTH-2:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    // Full-adder cell on the current LSBs.
    assign w_s       = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c       = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_last    = (r_cnt == LAST);
    assign w_res_nxt = {w_s, r_res};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_RUN:   o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // Subtraction as A + ~B + 1: invert B and force carry-in.
                        r_a_sh  <= i_A;
                        r_b_sh  <= i_Sub ? ~i_B : i_B;
                        r_carry <= i_Sub ? 1'b1 : i_Cin;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    r_res   <= w_res_nxt[WIDTH-1:1];
                    if (w_last) begin
                        r_sum  <= w_res_nxt;
                        r_cout <= w_c;
                        // r_carry here is the carry into the MSB.
                        r_ovf  <= w_c ^ r_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_Sum  = r_sum;
    assign o_Cout = r_cout;
    assign o_Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    bit chk_en = 1'b0;

    serial_addsub #(.WIDTH(W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_A    (a),
        .i_B    (b),
        .i_Cin  (cin),
        .i_Sub  (sub),
        .o_busy (busy),
        .o_done (done),
        .o_Sum  (sum),
        .o_Cout (cout),
        .o_Ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference arithmetic: plain integer add / subtract.
    function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic sb);
        if (sb)
            return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else
            return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    // Signed overflow from operand / result signs.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic sb, input logic [W-1:0] r);
        if (sb)
            return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else
            return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Timing model: an accepted start yields WIDTH busy cycles then one done cycle.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W:0]   p_full = '0;
    logic         p_ovf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_sum  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_sum  = p_full[W-1:0];
                m_cout = p_full[W];
                m_ovf  = p_ovf;
            end
        end else if (start) begin
            m_left = W;
            p_full = ref_full(a, b, cin, sub);
            p_ovf  = ref_ovf(a, b, sub, p_full[W-1:0]);
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (m_left > 0));
            chk("done", done, m_done);
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
            chk("ovf", ovf, m_ovf);
            if (done) done_seen++;
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input logic ev);
        int k;
        int busy_cnt;
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
        k = 1;
        busy_cnt = 0;
        while (!done && k < 30) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            k++;
        end
        chk("op_latency", k - 1, W);
        chk("op_busy_cycles", busy_cnt, W);
        chk("op_sum", sum, es);
        chk("op_cout", cout, ec);
        chk("op_ovf", ovf, ev);
    endtask

    initial begin
        int k;
        int extra_done;
        int extra_busy;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Hand-computed expectations.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start while busy, operand change mid-run, start during done.
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'h55; sub = 1'b1;
        k = 0;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("busy_test_done", done, 1'b1);
        chk("busy_test_sum", sum, 8'h30);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        repeat (12) begin
            extra_done += int'(done);
            extra_busy += int'(busy);
            @(negedge clk);
        end
        chk("busy_test_extra_done", extra_done, 0);
        chk("busy_test_extra_busy", extra_busy, 0);

        // Reset mid-operation.
        a = 8'h33; b = 8'h11; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_sum", sum, 8'h00);
        extra_done = 0;
        repeat (12) begin
            extra_done += int'(done);
            @(negedge clk);
        end
        chk("midrst_no_done", extra_done, 0);
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

        // Randomized traffic with stray starts, operand churn and occasional resets.
        done_seen = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("random_ops_completed", (done_seen > 30), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
